pulse_transmitter_stream: RTL and testbench

Streaming successor to the single-channel pulse transmitter. It takes symbol codes from a valid/ready stream into an internal FIFO and looks each code up in a writable table of level and duration entries. It then emits back-to-back pulses of (D+1)·2^P clocks, with optional carrier, idle level and inversion. The block is parametrised in symbol width, duration width, prescaler width and FIFO depth. Unlike the fixed-program transmitter, it adds streaming input, packet termination (sym_last) and underflow detection.

---
 rtl/pulse_transmitter_stream_pkg.sv | 20 ++
 rtl/pulse_transmitter_stream_if.sv | 12 +
 rtl/pulse_transmitter_sym_fifo.sv | 54 +++++
 rtl/pulse_transmitter_stream.sv | 140 ++++++++++++++
 tb/tb_pulse_transmitter_stream.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_transmitter_stream_pkg.sv
// Shared types and width helpers for the streaming pulse transmitter.
package pulse_transmitter_stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        UNDERRUN = 2'd2
    } state_t;

    // FIFO occupancy needs one bit more than the pointer so "full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Prescale counter must hold (1 << P) - 1 for the largest P.
    function automatic int presc_cnt_w(input int presc_w);
        return 2 ** presc_w;
    endfunction

endpackage

// File: rtl/pulse_transmitter_stream_if.sv
// Symbol stream handshake: producer drives valid/data/last, transmitter drives ready.
interface pulse_transmitter_stream_if #(
    parameter int SYM_W = 2
) ();
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_data;
    logic             sym_last;

    modport master (output sym_valid, output sym_data, output sym_last, input sym_ready);
    modport slave  (input sym_valid, input sym_data, input sym_last, output sym_ready);
endinterface

// File: rtl/pulse_transmitter_sym_fifo.sv
// Synchronous symbol FIFO with push, pop, flush and occupancy; flush beats a same-cycle push.
module pulse_transmitter_sym_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          do_push, do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count define validity, so contents never matter when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pulse_transmitter_stream.sv
// Streaming pulse transmitter: FIFO'd symbol codes index a level/duration table and
// are emitted back to back as (D+1)<<P clock pulses with optional carrier and inversion.
module pulse_transmitter_stream
    import pulse_transmitter_stream_pkg::*;
#(
    parameter int SYM_W      = 2,
    parameter int DUR_W      = 8,
    parameter int PRESC_W    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CARRIER_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           flush,
    input  logic                           cfg_idle_level,
    input  logic                           cfg_invert,
    input  logic                           cfg_carrier_en,
    input  logic [CARRIER_W-1:0]           cfg_carrier_half,
    input  logic [PRESC_W-1:0]             cfg_prescaler,
    input  logic                           tbl_wr_en,
    input  logic [SYM_W-1:0]               tbl_wr_idx,
    input  logic [DUR_W:0]                 tbl_wr_data,
    pulse_transmitter_stream_if.slave      sym,
    output logic                           pulse_out,
    output logic                           busy,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           done_irq,
    output logic                           underflow_irq
);

    localparam int TBL_N = 2 ** SYM_W;
    localparam int PS_W  = presc_cnt_w(PRESC_W);

    state_t                 state;
    logic [DUR_W:0]         tbl [TBL_N];
    logic [DUR_W-1:0]       dur_cnt;
    logic [PS_W-1:0]        presc_cnt, presc_max;
    logic                   cur_level, cur_last;
    logic [CARRIER_W-1:0]   car_cnt;
    logic                   car_phase;
    logic                   fifo_full, fifo_empty, fifo_push, load, final_tick, lvl;
    logic [SYM_W:0]         head;
    logic [DUR_W:0]         head_entry;

    assign sym.sym_ready = !fifo_full;
    assign fifo_push     = sym.sym_valid && !fifo_full;
    assign head_entry    = tbl[head[SYM_W-1:0]];
    assign presc_max     = ~({PS_W{1'b1}} << cfg_prescaler);
    assign final_tick    = (state == EMIT) && (dur_cnt == '0) && (presc_cnt == presc_max);
    assign load          = en && !fifo_empty && ((state != EMIT) || (final_tick && !cur_last));
    assign busy          = (state != IDLE);

    pulse_transmitter_sym_fifo #(.W(SYM_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (load),
        .flush   (flush),
        .wr_data ({sym.sym_last, sym.sym_data}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
        end else if (tbl_wr_en) begin
            tbl[tbl_wr_idx] <= tbl_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dur_cnt       <= '0;
            presc_cnt     <= '0;
            cur_level     <= 1'b0;
            cur_last      <= 1'b0;
            done_irq      <= 1'b0;
            underflow_irq <= 1'b0;
        end else begin
            done_irq      <= 1'b0;
            underflow_irq <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                dur_cnt   <= '0;
                presc_cnt <= '0;
            end else if (load) begin
                state     <= EMIT;
                cur_level <= head_entry[DUR_W];
                dur_cnt   <= head_entry[DUR_W-1:0];
                cur_last  <= head[SYM_W];
                presc_cnt <= '0;
            end else begin
                case (state)
                    IDLE, UNDERRUN: state <= state;
                    EMIT: begin
                        if (final_tick) begin
                            // A push arriving on this same cycle is not yet visible, so underrun wins.
                            state         <= cur_last ? IDLE : UNDERRUN;
                            done_irq      <= cur_last;
                            underflow_irq <= !cur_last;
                        end else if (presc_cnt == presc_max) begin
                            presc_cnt <= '0;
                            dur_cnt   <= dur_cnt - 1'b1;
                        end else begin
                            presc_cnt <= presc_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Carrier holds phase-high outside EMIT, so entry always starts high; it free-runs across back-to-back symbols.
    always_ff @(posedge clk) begin
        if (rst || !en || state != EMIT) begin
            car_cnt   <= '0;
            car_phase <= 1'b1;
        end else if (car_cnt == cfg_carrier_half) begin
            car_cnt   <= '0;
            car_phase <= !car_phase;
        end else begin
            car_cnt <= car_cnt + 1'b1;
        end
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        lvl = cfg_idle_level;
        if (state == EMIT) lvl = cfg_carrier_en ? (cur_level & car_phase) : cur_level;
    end

    assign pulse_out = lvl ^ cfg_invert;

endmodule

// File: tb/tb_pulse_transmitter_stream.sv
// Directed bench: table-driven cycle vectors plus hand sequences for multi-cycle corners.
module tb_pulse_transmitter_stream;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic        cfg_idle_level, cfg_invert, cfg_carrier_en;
    logic [15:0] cfg_carrier_half;
    logic [2:0]  cfg_prescaler;
    logic        tbl_wr_en;
    logic [1:0]  tbl_wr_idx;
    logic [8:0]  tbl_wr_data;
    logic        pulse_out, busy, done_irq, underflow_irq;
    logic [3:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_transmitter_stream_if #(.SYM_W(2)) sif ();

    pulse_transmitter_stream dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .flush            (flush),
        .cfg_idle_level   (cfg_idle_level),
        .cfg_invert       (cfg_invert),
        .cfg_carrier_en   (cfg_carrier_en),
        .cfg_carrier_half (cfg_carrier_half),
        .cfg_prescaler    (cfg_prescaler),
        .tbl_wr_en        (tbl_wr_en),
        .tbl_wr_idx       (tbl_wr_idx),
        .tbl_wr_data      (tbl_wr_data),
        .sym              (sif),
        .pulse_out        (pulse_out),
        .busy             (busy),
        .fifo_level       (fifo_level),
        .done_irq         (done_irq),
        .underflow_irq    (underflow_irq)
    );

    typedef struct {
        logic       en;
        logic       v;
        logic [1:0] code;
        logic       last;
        logic       pulse;
        logic       busy;
        logic       done;
        logic       uf;
        logic       rdy;
        logic [3:0] lvl;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [1:0] idx, input logic lvl, input logic [7:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = idx;
        tbl_wr_data = {lvl, d};
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic set_stream(input logic v, input logic [1:0] code, input logic last);
        sif.sym_valid = v;
        sif.sym_data  = code;
        sif.sym_last  = last;
    endtask

    function automatic vec_t mk(input logic e, input logic v, input logic [1:0] code, input logic last,
                                input logic p, input logic b, input logic d, input logic u,
                                input logic r, input logic [3:0] l);
        vec_t x;
        x.en = e; x.v = v; x.code = code; x.last = last;
        x.pulse = p; x.busy = b; x.done = d; x.uf = u; x.rdy = r; x.lvl = l;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int hi, dn, irq;

        // Single symbol {1,3}, P=0: high cycles 2..5, done at 6.
        vecs[0]  = mk(1, 1, 2'd0, 1, 0, 0, 0, 0, 1, 4'd0);
        vecs[1]  = mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 1, 4'd1);
        vecs[2]  = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[3]  = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[4]  = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[5]  = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[6]  = mk(1, 0, 2'd0, 0, 0, 0, 1, 0, 1, 4'd0);
        vecs[7]  = mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 1, 4'd0);
        // Packet 1,2,3(last): widths 3 (low), 1, 5 with no gaps.
        vecs[8]  = mk(1, 1, 2'd1, 0, 0, 0, 0, 0, 1, 4'd0);
        vecs[9]  = mk(1, 1, 2'd2, 0, 0, 0, 0, 0, 1, 4'd1);
        vecs[10] = mk(1, 1, 2'd3, 1, 0, 1, 0, 0, 1, 4'd1);
        vecs[11] = mk(1, 0, 2'd0, 0, 0, 1, 0, 0, 1, 4'd2);
        vecs[12] = mk(1, 0, 2'd0, 0, 0, 1, 0, 0, 1, 4'd2);
        vecs[13] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd1);
        vecs[14] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[15] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[16] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[17] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[18] = mk(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 4'd0);
        vecs[19] = mk(1, 0, 2'd0, 0, 0, 0, 1, 0, 1, 4'd0);

        rst = 1'b1; en = 1'b0; flush = 1'b0;
        cfg_idle_level = 1'b1; cfg_invert = 1'b0; cfg_carrier_en = 1'b0;
        cfg_carrier_half = 16'd0; cfg_prescaler = 3'd0;
        tbl_wr_en = 1'b0; tbl_wr_idx = 2'd0; tbl_wr_data = 9'd0;
        set_stream(0, 2'd0, 0);
        tick();
        tick();
        check("rst_pulse", 32'(pulse_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(sif.sym_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_done", 32'(done_irq), 32'd0);
        check("rst_uf", 32'(underflow_irq), 32'd0);

        rst = 1'b0; cfg_idle_level = 1'b0; en = 1'b1;
        tbl_write(2'd0, 1'b1, 8'd3);
        tbl_write(2'd1, 1'b0, 8'd2);
        tbl_write(2'd2, 1'b1, 8'd0);
        tbl_write(2'd3, 1'b1, 8'd4);

        for (int i = 0; i < 20; i++) begin
            en = vecs[i].en;
            set_stream(vecs[i].v, vecs[i].code, vecs[i].last);
            #1;
            check($sformatf("vec%0d_pulse", i), 32'(pulse_out), 32'(vecs[i].pulse));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), 32'(done_irq), 32'(vecs[i].done));
            check($sformatf("vec%0d_uf", i), 32'(underflow_irq), 32'(vecs[i].uf));
            check($sformatf("vec%0d_ready", i), 32'(sif.sym_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
            @(posedge clk);
            #1;
        end
        set_stream(0, 2'd0, 0);

        // Prescaler P=2, {1,1}: exactly 8 high clocks starting two cycles after the push.
        tbl_write(2'd1, 1'b1, 8'd1);
        cfg_prescaler = 3'd2;
        set_stream(1, 2'd1, 1);
        tick();
        set_stream(0, 2'd0, 0);
        tick();
        check("p2_start", 32'(pulse_out), 32'd1);
        hi = 0; dn = 0;
        for (int i = 0; i < 12; i++) begin
            hi += int'(pulse_out);
            dn += int'(done_irq);
            tick();
        end
        check("p2_width", 32'(hi), 32'd8);
        check("p2_done_count", 32'(dn), 32'd1);
        cfg_prescaler = 3'd0;

        // Underflow: code 3 (D=4) without last, then resume with code 2 last.
        set_stream(1, 2'd3, 0);
        tick();
        set_stream(0, 2'd0, 0);
        tick();
        check("uf_first_hi", 32'(pulse_out), 32'd1);
        repeat (4) tick();
        check("uf_last_hi", 32'(pulse_out), 32'd1);
        check("uf_not_early", 32'(underflow_irq), 32'd0);
        tick();
        check("uf_irq", 32'(underflow_irq), 32'd1);
        check("uf_pulse_idle", 32'(pulse_out), 32'd0);
        check("uf_busy", 32'(busy), 32'd1);
        tick();
        check("uf_irq_once", 32'(underflow_irq), 32'd0);
        check("uf_busy_hold", 32'(busy), 32'd1);
        set_stream(1, 2'd2, 1);
        tick();
        set_stream(0, 2'd0, 0);
        tick();
        check("uf_resume_hi", 32'(pulse_out), 32'd1);
        tick();
        check("uf_resume_done", 32'(done_irq), 32'd1);
        check("uf_resume_idle", 32'(busy), 32'd0);

        // Push landing on the final tick is not seen: underflow still fires, then it is emitted.
        set_stream(1, 2'd3, 0);
        tick();
        set_stream(0, 2'd0, 0);
        repeat (5) tick();
        set_stream(1, 2'd2, 1);
        tick();
        set_stream(0, 2'd0, 0);
        check("late_push_uf", 32'(underflow_irq), 32'd1);
        check("late_push_idle", 32'(pulse_out), 32'd0);
        tick();
        check("late_push_hi", 32'(pulse_out), 32'd1);
        tick();
        check("late_push_done", 32'(done_irq), 32'd1);

        // Fill with en=0: 8 accepted, ready drops; flush empties and drops a same-cycle push.
        en = 1'b0;
        set_stream(1, 2'd1, 0);
        repeat (9) tick();
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_ready", 32'(sif.sym_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_stream(0, 2'd0, 0);
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_ready", 32'(sif.sym_ready), 32'd1);
        set_stream(1, 2'd1, 0);
        tick();
        check("one_push_level", 32'(fifo_level), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_stream(0, 2'd0, 0);
        check("flush_drops_push", 32'(fifo_level), 32'd0);

        // Carrier half=1 on {1,7}: 1,1,0,0,1,1,0,0, then the complement with inversion.
        en = 1'b1;
        tbl_write(2'd0, 1'b1, 8'd7);
        cfg_carrier_half = 16'd1;
        cfg_carrier_en = 1'b1;
        pat = 8'b0011_0011;
        for (int inv = 0; inv < 2; inv++) begin
            cfg_invert = inv[0];
            #1;
            check($sformatf("car_idle_inv%0d", inv), 32'(pulse_out), 32'(inv));
            set_stream(1, 2'd0, 1);
            tick();
            set_stream(0, 2'd0, 0);
            tick();
            for (int i = 0; i < 8; i++) begin
                check($sformatf("car_inv%0d_c%0d", inv, i), 32'(pulse_out), 32'(pat[i] ^ inv[0]));
                tick();
            end
            check($sformatf("car_done_inv%0d", inv), 32'(done_irq), 32'd1);
            check($sformatf("car_after_inv%0d", inv), 32'(pulse_out), 32'(inv));
        end
        cfg_invert = 1'b0;
        cfg_carrier_en = 1'b0;

        // Drop en mid-symbol: idle next cycle, no irq, queued code 2 survives and is sent later.
        en = 1'b0;
        set_stream(1, 2'd0, 0);
        tick();
        set_stream(1, 2'd2, 1);
        tick();
        set_stream(0, 2'd0, 0);
        check("drop_queued", 32'(fifo_level), 32'd2);
        en = 1'b1;
        tick();
        check("drop_emit_hi", 32'(pulse_out), 32'd1);
        check("drop_emit_level", 32'(fifo_level), 32'd1);
        tick();
        en = 1'b0;
        check("drop_still_hi", 32'(pulse_out), 32'd1);
        tick();
        check("drop_idle", 32'(pulse_out), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_level_kept", 32'(fifo_level), 32'd1);
        irq = int'(done_irq) + int'(underflow_irq);
        check("drop_no_irq", 32'(irq), 32'd0);
        en = 1'b1;
        tick();
        check("drop_resume_hi", 32'(pulse_out), 32'd1);
        check("drop_resume_no_irq", 32'(done_irq | underflow_irq), 32'd0);
        tick();
        check("drop_resume_done", 32'(done_irq), 32'd1);
        check("drop_fifo_empty", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
